// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared types and sizing helpers for full_counter
//   COUNT_W    : width of the count bus
//   fsm_t      : run-control state encoding
//   calc_div   : clock cycles per count step
//   calc_pre_w : prescaler register width for a given divider
package counter_pkg;

    localparam int COUNT_W = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } fsm_t;

    function automatic int calc_div(input int clk_hz, input int tick_hz);
        return clk_hz / tick_hz;
    endfunction

    // A divider of 2 still needs one bit to hold 0..1.
    function automatic int calc_pre_w(input int div);
        return (div > 2) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/btn_cond.sv
// rtl/btn_cond.sv - raw button conditioning: 2-flop sync, optional debounce, rising-edge detect
//   clk       : system clock
//   rst       : synchronous active-high reset
//   btn_raw   : asynchronous active-high button
//   btn_event : one-cycle pulse per accepted press
// Optional debouncer is built when COUNTER_DEBOUNCE_EN is defined.
module btn_cond
    import counter_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_event
);

    logic sync1_q;
    logic sync2_q;
    logic hist_q;
    logic level;

    // Synchronizer and history reset high so a button held through reset
    // cannot look like a fresh press afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
        end
    end

`ifdef COUNTER_DEBOUNCE_EN
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic            deb_q;
    logic [DB_W-1:0] db_cnt_q;

    // The filtered level only follows the synchronized level once it has
    // disagreed for DEBOUNCE_CYCLES consecutive cycles; any agreement in
    // between restarts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            deb_q    <= 1'b1;
            db_cnt_q <= '0;
        end else if (sync2_q != deb_q) begin
            if (db_cnt_q == DB_LAST) begin
                deb_q    <= sync2_q;
                db_cnt_q <= '0;
            end else begin
                db_cnt_q <= db_cnt_q + 1'b1;
            end
        end else begin
            db_cnt_q <= '0;
        end
    end

    assign level = deb_q;
`else
    logic unused_debounce_cfg;
    assign unused_debounce_cfg = ^DEBOUNCE_CYCLES;
    assign level = sync2_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= 1'b1;
        end else begin
            hist_q <= level;
        end
    end

    assign btn_event = level & ~hist_q;

endmodule

// File: rtl/full_counter.sv
// rtl/full_counter.sv - mod-(MAX_COUNT+1) up/down counter with start/stop, clear and load
//   clk            : system clock
//   rst            : synchronous active-high reset
//   btn_start_stop : raw button, toggles RUN/PAUSE, starts from IDLE
//   btn_clear      : raw button, returns to IDLE with count 0
//   up_down        : 1 = count up, 0 = count down
//   load_en        : level load strobe
//   load_val       : value to load, saturated to MAX_COUNT
//   state          : current count, 0..MAX_COUNT
//   tick           : one-cycle pulse on each count step
//   running        : high while in RUN
//   wrap           : one-cycle pulse with tick when the count wraps
// Optional button debouncing: define COUNTER_DEBOUNCE_EN.
module full_counter
    import counter_pkg::*;
#(
    parameter int CLK_HZ          = 50_000_000,
    parameter int TICK_HZ         = 1,
    parameter int MAX_COUNT       = 99,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               btn_start_stop,
    input  logic               btn_clear,
    input  logic               up_down,
    input  logic               load_en,
    input  logic [COUNT_W-1:0] load_val,
    output logic [COUNT_W-1:0] state,
    output logic               tick,
    output logic               running,
    output logic               wrap
);

    localparam int                 DIV      = calc_div(CLK_HZ, TICK_HZ);
    localparam int                 PRE_W    = calc_pre_w(DIV);
    localparam logic [PRE_W-1:0]   PRE_LAST = PRE_W'(DIV - 1);
    localparam logic [COUNT_W-1:0] MAX_C    = COUNT_W'(MAX_COUNT);

    logic ss_event;
    logic clr_event;

    btn_cond #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_start_stop (
        .clk      (clk),
        .rst      (rst),
        .btn_raw  (btn_start_stop),
        .btn_event(ss_event)
    );

    btn_cond #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_clear (
        .clk      (clk),
        .rst      (rst),
        .btn_raw  (btn_clear),
        .btn_event(clr_event)
    );

    fsm_t               fsm_q;
    fsm_t               fsm_d;
    logic [PRE_W-1:0]   pre_q;
    logic [PRE_W-1:0]   pre_d;
    logic [COUNT_W-1:0] state_d;
    logic [COUNT_W-1:0] load_sat;
    logic [COUNT_W-1:0] step_val;
    logic               at_limit;
    logic               step_en;

    // A step is due at the end of each full prescaler period in RUN; clear
    // and load both pre-empt it in the same cycle.
    assign step_en  = (fsm_q == RUN) && (pre_q == PRE_LAST) && !clr_event && !load_en;
    assign at_limit = up_down ? (state == MAX_C) : (state == '0);
    assign tick     = step_en;
    assign wrap     = step_en && at_limit;

    assign load_sat = (load_val > MAX_C) ? MAX_C : load_val;

    always_comb begin
        step_val = state;
        if (up_down) begin
            step_val = at_limit ? '0 : state + 1'b1;
        end else begin
            step_val = at_limit ? MAX_C : state - 1'b1;
        end
    end

    // Run control. A start/stop press that coincides with a step still lets
    // the step happen; only the state changes.
    always_comb begin
        fsm_d = fsm_q;
        if (clr_event) begin
            fsm_d = IDLE;
        end else if (!load_en && ss_event) begin
            case (fsm_q)
                IDLE:    fsm_d = RUN;
                RUN:     fsm_d = PAUSE;
                PAUSE:   fsm_d = RUN;
                default: fsm_d = IDLE;
            endcase
        end
    end

    // Prescaler holds through PAUSE so a resume finishes the partial period.
    always_comb begin
        pre_d = pre_q;
        if (clr_event || load_en) begin
            pre_d = '0;
        end else begin
            case (fsm_q)
                RUN:     pre_d = step_en ? '0 : pre_q + 1'b1;
                PAUSE:   pre_d = pre_q;
                default: pre_d = '0;
            endcase
        end
    end

    always_comb begin
        state_d = state;
        if (clr_event) begin
            state_d = '0;
        end else if (load_en) begin
            state_d = load_sat;
        end else if (step_en) begin
            state_d = step_val;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q   <= IDLE;
            pre_q   <= '0;
            state   <= '0;
            running <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            pre_q   <= pre_d;
            state   <= state_d;
            running <= (fsm_d == RUN);
        end
    end

endmodule

// File: doc/full_counter.md
Name: full_counter

Overview:
- Mod-100 up/down seconds-style counter with start/stop and clear buttons and a parallel load.
- Produces the 7-bit binary count that feeds the binary-to-BCD and 7-segment display stage directly downstream.
- The count output is always in the range 0..MAX_COUNT, so the downstream BCD conversion never sees an out-of-range value.

Parameters:
CLK_HZ, 50_000_000, input clock frequency
TICK_HZ, 1, count rate; DIV = CLK_HZ/TICK_HZ; DIV must be >= 2
MAX_COUNT, 99, highest count value; must be <= 127
DEBOUNCE_CYCLES, 1_000_000, stable cycles required per button (used only with the optional feature)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
btn_start_stop  in  1  asynchronous raw button, active-high
btn_clear  in  1  asynchronous raw button, active-high
up_down  in  1  1 = count up, 0 = count down; sampled on each tick
load_en  in  1  synchronous level load strobe
load_val  in  7  value to load
state  out  7  current count, 0..MAX_COUNT
tick  out  1  one-cycle pulse when a count step occurs
running  out  1  high while the FSM is in RUN
wrap  out  1  one-cycle pulse, coincident with tick, when the count wraps

Behaviour:
- One clock domain. Reset is synchronous and active-high (rst sampled on clk rising edge).
- Reset values:
  - state = 0, tick = 0, running = 0, wrap = 0.
  - FSM = IDLE, prescaler = 0.
  - All button synchronizer and edge-history flops = 1, so a button held through reset produces no event until it is released and pressed again.
- Button path: 2-flop synchronizer, then rising-edge detect (history flop). The event is a 1-cycle pulse. A rising input sampled at edge 1 changes the FSM at edge 3.
- FSM states:
  - IDLE: start_stop event -> RUN.
  - RUN: start_stop event -> PAUSE.
  - PAUSE: start_stop event -> RUN.
  - Any state: clear event -> IDLE with state = 0.
- Priority, highest first: rst > clear event > load_en > start_stop event / tick.
  - Clear and start_stop events in the same cycle: clear wins; FSM = IDLE.
- Prescaler behaviour by state:
  - RUN: counts 0..DIV-1. tick = 1 combinationally while in RUN and prescaler == DIV-1; the prescaler then returns to 0.
  - PAUSE: prescaler holds its value, so resume continues the partial period.
  - IDLE: prescaler forced to 0.
- Count step on tick (state updates at the same edge that ends the tick cycle):
  - up_down = 1: state == MAX_COUNT -> 0 with wrap = 1; otherwise state + 1.
  - up_down = 0: state == 0 -> MAX_COUNT with wrap = 1; otherwise state - 1.
  - wrap is asserted in the same cycle as tick.
- Load:
  - load_en = 1: state <= (load_val > MAX_COUNT) ? MAX_COUNT : load_val.
  - Prescaler <= 0; FSM unchanged.
  - A tick in the same cycle is suppressed (tick = 0, wrap = 0).
- running = (FSM == RUN), registered.
- A start_stop event coinciding with a tick in RUN: the count step occurs and the FSM moves to PAUSE.

Optional Feature:
- Macro: COUNTER_DEBOUNCE_EN.
- Defined: after synchronization, each button passes a debouncer. The debounced level updates only after the synchronized level differs from it for DEBOUNCE_CYCLES consecutive cycles; any bounce resets the stability counter. Edge detect runs on the debounced level. Press-to-FSM latency = 2 + DEBOUNCE_CYCLES + 1 edges. Debounced level resets to 1.
- Undefined: no debouncer; DEBOUNCE_CYCLES is ignored; latency is 3 edges.

Decomposition:
- counter_pkg:
  - typedef enum logic [1:0] fsm_t {IDLE, RUN, PAUSE}
  - localparam COUNT_W = 7
  - function computing DIV and the prescaler width ($clog2(DIV))
- Sub-module btn_cond (synchronizer + optional debouncer + edge detect): one per button, two instances.

Test Plan (CLK_HZ=10, TICK_HZ=1 so DIV=10; DEBOUNCE_CYCLES=4):
- Reset, pulse start_stop -> running = 1 three edges later; first tick 10 cycles after RUN entry; after 25 ticks state = 25, wrap never asserted.
- Load 98, up_down = 1, RUN -> ticks give state 99 then 0; wrap = 1 only with the second tick. Load 120 -> state = 99.
- state = 0, up_down = 0, RUN -> next tick gives state = 99 with wrap = 1.
- Press start_stop when prescaler = 4 -> PAUSE; hold 30 cycles with no tick and state unchanged; press again -> first tick exactly 6 cycles after RUN re-entry.
- clear and start_stop rise in the same cycle while in RUN -> FSM = IDLE, state = 0, running = 0, prescaler = 0.
- rst asserted mid-RUN with start_stop held high -> state = 0, IDLE; no start until release and re-press. With COUNTER_DEBOUNCE_EN defined, a 3-cycle glitch produces no event.
